// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry FWFT queue toward decode.
// Fetch-to-decode latency 1 cycle; fetch stalls when the queue is full and not being popped.
module fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    entry_t                storage [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  pop;
    logic                  push;
    entry_t                head;

    assign out_valid = !rst && (count != '0);
    assign pop       = out_valid && out_ready;
    // A full queue that is draining this cycle frees a slot in time for the new word.
    assign imem_req  = !rst && !redirect_en && ((count < CNT_W'(DEPTH)) || pop);
    assign push      = imem_req && imem_ready;
    assign imem_addr = fetch_pc;

    assign head        = storage[rd_ptr];
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign out_pc_next = head.pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_en) begin
            // Flush by catching the read pointer up to the write pointer.
            fetch_pc <= redirect_addr;
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= '{instr: imem_data, pc: fetch_pc};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam logic [31:0] STEP  = 32'd4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic          imem_ready;
    logic [DW-1:0] imem_data;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_next;

    fetch_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RPC),
        .PC_STEP   (STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .redirect_en  (redirect_en),
        .redirect_addr(redirect_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_next  (out_pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    bit          rand_data;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
    task automatic step(input logic r, input logic re, input logic [31:0] ra,
                        input logic ir, input logic ordy);
        logic ev;
        logic er;
        logic [31:0] data;
        @(negedge clk);
        data          = rand_data ? $urandom : m_fpc;
        rst           = r;
        redirect_en   = re;
        redirect_addr = ra;
        imem_ready    = ir;
        out_ready     = ordy;
        imem_data     = data;
        #1;
        ev = !r && (mq.size() != 0);
        er = !r && !re && ((mq.size() < DEPTH) || (ev && ordy));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("imem_req", 32'(imem_req), 32'(er));
        if (!r) chk("imem_addr", imem_addr, m_fpc);
        if (ev) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_pc_next", out_pc_next, mq[0].pc + STEP);
        end
        if (r) begin
            mq.delete();
            m_fpc = RPC;
        end else if (re) begin
            mq.delete();
            m_fpc = ra;
        end else begin
            if (ev && ordy) void'(mq.pop_front());
            if (er && ir) begin
                mq.push_back('{instr: data, pc: m_fpc});
                m_fpc = m_fpc + STEP;
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rand_data     = 1'b0;
        m_fpc         = RPC;
        rst           = 1'b1;
        redirect_en   = 1'b0;
        redirect_addr = '0;
        imem_ready    = 1'b0;
        imem_data     = '0;
        out_ready     = 1'b0;

        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Free run from reset, data = address, pc wraps through zero
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, RPC);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("c1_valid", 32'(out_valid), 32'd1);
        chk("c1_pc", out_pc, RPC);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("c2_pc", out_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("c3_pc_wrap", out_pc, 32'd0);
        chk("c3_instr", out_instr, 32'd0);
        chk("c3_pc_next", out_pc_next, 32'd4);
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Mid-stream reset with entries queued
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("mrst_restart", imem_addr, RPC);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Backpressure fill then drain
        step(1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            chk("full_req", 32'(imem_req), 32'd0);
            chk("full_addr", imem_addr, 32'h10);
            chk("full_head", out_pc, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            chk("drain_pc", out_pc, 32'(i * 4));
            chk("drain_valid", 32'(out_valid), 32'd1);
        end

        // Redirect with three entries queued
        step(1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h400);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("redir_head", out_pc, 32'h400);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("redir_next", out_pc, 32'h404);

        // Memory wait states: ready pattern 1,0,0,1
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("ws_pc0", out_pc, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("ws_pc1", out_pc, 32'd4);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("ws_empty", 32'(out_valid), 32'd0);

        // Random traffic
        rand_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom,
                 $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
